cfg_byte_loader: RTL and testbench
==================================

CFG_BYTE_LOADER -- requirements
Module: cfg_byte_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, register-file address width; must be a multiple of 8.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, register-file data width; must be a multiple of 8.
REQ-003 SHALL have parameter NUM_REGISTERS, default 8, count of writable registers downstream.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, on ports `clk` and `rst`.
REQ-005 Port `clk`: input, 1 bit, rising-edge clock for all state.
REQ-006 Port `rst`: input, 1 bit, asynchronous, active-low reset.
REQ-007 Port `in_valid`: input, 1 bit, byte-stream valid.
REQ-008 Port `in_data`: input, 8 bits, byte-stream payload.
REQ-009 Port `in_ready`: output, 1 bit, loader can accept a byte this cycle.
REQ-010 Port `write_enable`: output, 1 bit, one-cycle register-file write strobe.
REQ-011 Port `write_addr`: output, ADDR_WIDTH bits, register-file write address.
REQ-012 Port `write_data`: output, DATA_WIDTH bits, register-file write data.
REQ-013 Port `err_csum`: output, 1 bit, one-cycle pulse when the frame checksum mismatches.
REQ-014 Port `err_range`: output, 1 bit, one-cycle pulse when the address is >= NUM_REGISTERS.
REQ-015 Port `frame_count`: output, 8 bits, saturating count of frames written.
REQ-016 Port `busy`: output, 1 bit, high when the state is not IDLE.

Function
REQ-017 Byte transfer SHALL occur only on a rising clk edge where in_valid and in_ready are both 1.
REQ-018 Frame format SHALL be: sync 0xA5, then ADDR_WIDTH/8 address bytes MSB-first, then DATA_WIDTH/8 data bytes MSB-first, then one checksum byte.
REQ-019 Checksum SHALL be the XOR of all address and data bytes; the sync byte is excluded.
REQ-020 FSM states SHALL be IDLE, ADDR, DATA, CSUM, DONE.
REQ-021 Transitions: IDLE->ADDR on an accepted 0xA5; ADDR->DATA after the last address byte; DATA->CSUM after the last data byte; CSUM->DONE on the accepted checksum byte; DONE->IDLE unconditionally after one cycle.
REQ-022 In IDLE, every accepted byte other than 0xA5 SHALL be discarded with no output effect.
REQ-023 A 0xA5 byte inside ADDR/DATA/CSUM SHALL be treated as payload, not as a resync.
REQ-024 in_ready SHALL be 1 in IDLE, ADDR, DATA and CSUM, and 0 in DONE.
REQ-025 In DONE, with a good checksum and address < NUM_REGISTERS: write_enable=1 for exactly that cycle, with write_addr/write_data holding the frame values.
REQ-026 In DONE with a bad checksum: err_csum=1 for one cycle, no write; err_range SHALL NOT assert (checksum error has priority).
REQ-027 In DONE with a good checksum and out-of-range address: err_range=1 for one cycle, no write.
REQ-028 Latency: write_enable SHALL assert in the cycle immediately after the checksum byte is accepted.
REQ-029 write_addr and write_data SHALL hold their last assembled values when write_enable=0.
REQ-030 frame_count SHALL increment on each write_enable and saturate at 0xFF (no wrap).
REQ-031 in_valid with in_ready=0 SHALL not consume the byte; the upstream source holds it.

Reset
REQ-032 rst low SHALL asynchronously force state IDLE and discard any partial frame.
REQ-033 While rst is low, all outputs SHALL be 0 except in_ready, which SHALL be 1 after reset release.
REQ-034 The first frame after reset release SHALL be processed normally.

Structure
REQ-035 Shared package cfg_loader_pkg SHALL hold SYNC_BYTE (0xA5) and the FSM state enumeration.
REQ-036 No sub-module SHALL be used: byte shift registers, running XOR and byte counter all live inline.
REQ-037 The byte counter SHALL be sized for max(ADDR_WIDTH, DATA_WIDTH)/8.

Verification (defaults 16/16/8)
REQ-038 Bytes A5 00 03 12 34 25 -> write_enable one cycle after 0x25 is accepted, addr 0x0003, data 0x1234, frame_count 1.
REQ-039 Bytes A5 00 03 12 34 26 -> err_csum pulse, no write, frame_count unchanged.
REQ-040 Bytes A5 00 08 00 01 09 -> err_range pulse, no write.
REQ-041 Bytes 00 FF 3C then A5 00 01 AB CD 67 -> leading bytes dropped, write addr 1, data 0xABCD.
REQ-042 rst pulsed low after A5 00 03, then A5 00 02 00 A5 A7 -> no write from the partial frame; write addr 2, data 0x00A5.
REQ-043 in_valid held high across back-to-back frames -> in_ready=0 exactly in each DONE cycle, no byte lost; 256+ good frames -> frame_count stays 0xFF.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration byte loader: sync marker,
// FSM state encoding and a small elaboration-time helper.
package cfg_loader_pkg;

  // Frame start marker; outside a frame every other byte is dropped.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Loader states in frame order.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4
  } state_t;

  // Larger of two integers, used to size the shared byte counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cfg_byte_loader.sv
// Byte-stream configuration loader.
// Parses frames of the form  A5 | addr bytes (MSB first) | data bytes
// (MSB first) | XOR checksum  and issues one register-file write per good
// frame. Bad checksums and out-of-range addresses raise one-cycle error
// pulses instead. ADDR_WIDTH and DATA_WIDTH are expected to be multiples
// of 8.
module cfg_byte_loader
  import cfg_loader_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_REGISTERS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  err_csum,
  output logic                  err_range,
  output logic [7:0]            frame_count,
  output logic                  busy
);

  localparam int ABYTES = ADDR_WIDTH / 8;
  localparam int DBYTES = DATA_WIDTH / 8;
  localparam int NBYTES = max_int(ABYTES, DBYTES);
  // One counter serves both the address and the data field.
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ABYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DBYTES - 1);
  // Range compare is done at least 32 bits wide so NUM_REGISTERS is never truncated.
  localparam int CMP_W  = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_sr;
  logic [DATA_WIDTH-1:0]   data_sr;
  logic [7:0]              csum;
  logic [CNT_W-1:0]        cnt;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [DATA_WIDTH-1:0]   data_next;

  // Saturating frame counter increment: sticks at 0xFF.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // True when the assembled address targets an existing register.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return CMP_W'(a) < CMP_W'(NUM_REGISTERS);
  endfunction

  assign accept    = in_valid & in_ready;
  // Shift the new byte in at the LSB end; the oldest (MSB) byte falls off.
  assign addr_next = ADDR_WIDTH'({addr_sr, in_data});
  assign data_next = DATA_WIDTH'({data_sr, in_data});

  // Frame FSM with all outputs registered; strobes are high only in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      addr_sr      <= '0;
      data_sr      <= '0;
      csum         <= '0;
      cnt          <= '0;
      in_ready     <= 1'b1;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      err_csum     <= 1'b0;
      err_range    <= 1'b0;
      frame_count  <= '0;
      busy         <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      err_csum     <= 1'b0;
      err_range    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && in_data == SYNC_BYTE) begin
            state <= ADDR;
            busy  <= 1'b1;
            cnt   <= '0;
            csum  <= '0;
          end
        end
        ADDR: begin
          if (accept) begin
            addr_sr <= addr_next;
            csum    <= csum ^ in_data;
            if (cnt == ADDR_LAST) begin
              cnt   <= '0;
              state <= DATA;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (accept) begin
            data_sr <= data_next;
            csum    <= csum ^ in_data;
            if (cnt == DATA_LAST) begin
              cnt   <= '0;
              state <= CSUM;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        CSUM: begin
          if (accept) begin
            state      <= DONE;
            in_ready   <= 1'b0;
            write_addr <= addr_sr;
            write_data <= data_sr;
            // Checksum failure wins over the range check.
            if (csum != in_data) begin
              err_csum <= 1'b1;
            end else if (!addr_in_range(addr_sr)) begin
              err_range <= 1'b1;
            end else begin
              write_enable <= 1'b1;
              frame_count  <= sat_inc(frame_count);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_byte_loader.sv
// Self-checking bench for cfg_byte_loader (default 16/16/8 configuration).
module tb_cfg_byte_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        write_enable;
  logic [15:0] write_addr;
  logic [15:0] write_data;
  logic        err_csum;
  logic        err_range;
  logic [7:0]  frame_count;
  logic        busy;

  cfg_byte_loader #(
    .ADDR_WIDTH   (16),
    .DATA_WIDTH   (16),
    .NUM_REGISTERS(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .err_csum    (err_csum),
    .err_range   (err_range),
    .frame_count (frame_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_fc = 0;

  typedef struct {
    logic [71:0] bytes;   // up to 9 bytes, first byte in bits [71:64]
    int          len;
    bit          we;
    bit          ec;
    bit          er;
    logic [15:0] addr;
    logic [15:0] data;
  } vec_t;

  vec_t vecs [4];

  // Observed strobes, collected away from the active edge.
  logic [31:0] wr_q [$];
  int          ec_n, er_n, rdy_low_n;

  // Expected results from the reference model.
  logic [31:0] exp_wr [$];
  int          exp_ec, exp_er;

  always @(negedge clk) begin
    if (rst) begin
      if (write_enable) wr_q.push_back({write_addr, write_data});
      if (err_csum)     ec_n++;
      if (err_range)    er_n++;
      if (!in_ready)    rdy_low_n++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Present one byte from a negedge and return at the negedge after it is taken.
  task automatic send_byte(input logic [7:0] b);
    int g;
    g        = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && g < 16) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at %0b, expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Frame-level reference: locate each A5, slice the following five bytes
  // as addr/data/checksum and classify the result.
  task automatic model_stream(input logic [7:0] s [$]);
    int          i;
    logic [15:0] a, d;
    logic [7:0]  x;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5 || i + 5 >= s.size()) begin
        i++;
      end else begin
        a = {s[i+1], s[i+2]};
        d = {s[i+3], s[i+4]};
        x = s[i+1] ^ s[i+2] ^ s[i+3] ^ s[i+4];
        if (x != s[i+5])    exp_ec++;
        else if (a >= 16'd8) exp_er++;
        else begin
          exp_wr.push_back({a, d});
          exp_fc = (exp_fc >= 255) ? 255 : exp_fc + 1;
        end
        i += 6;
      end
    end
  endtask

  task automatic clear_obs();
    wr_q.delete();
    exp_wr.delete();
    ec_n = 0; er_n = 0; rdy_low_n = 0;
    exp_ec = 0; exp_er = 0;
  endtask

  task automatic compare_obs(input string tag);
    check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int k = 0; k < exp_wr.size() && k < wr_q.size(); k++)
      check({tag, "_wr_entry"}, wr_q[k], exp_wr[k]);
    check({tag, "_csum_errs"}, 32'(ec_n), 32'(exp_ec));
    check({tag, "_range_errs"}, 32'(er_n), 32'(exp_er));
    check({tag, "_frame_count"}, 32'(frame_count), 32'(exp_fc));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] stream [$];
    logic [7:0] b;
    logic [15:0] a, d;
    logic [7:0] x;

    vecs[0] = '{72'hA5_00_03_12_34_25_00_00_00, 6, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h1234};
    vecs[1] = '{72'hA5_00_03_12_34_26_00_00_00, 6, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{72'hA5_00_08_00_01_09_00_00_00, 6, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000};
    vecs[3] = '{72'h00_FF_3C_A5_00_01_AB_CD_67, 9, 1'b1, 1'b0, 1'b0, 16'h0001, 16'hABCD};

    ec_n = 0; er_n = 0; rdy_low_n = 0; exp_ec = 0; exp_er = 0;
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_we",    32'(write_enable), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_fc",    32'(frame_count), 0);
    check("rst_errs",  32'({err_csum, err_range}), 0);
    check("rst_waddr", 32'(write_addr), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(in_ready), 1);

    // Directed frame vectors; outcome is checked one cycle after the checksum byte.
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < vecs[v].len; k++) begin
        b = vecs[v].bytes[71 - 8*k -: 8];
        send_byte(b);
      end
      if (vecs[v].we) exp_fc++;
      check("vec_we",    32'(write_enable), 32'(vecs[v].we));
      check("vec_ecsum", 32'(err_csum),     32'(vecs[v].ec));
      check("vec_erng",  32'(err_range),    32'(vecs[v].er));
      check("vec_ready_done", 32'(in_ready), 0);
      check("vec_fc",    32'(frame_count),  32'(exp_fc));
      if (vecs[v].we) begin
        check("vec_addr", 32'(write_addr), 32'(vecs[v].addr));
        check("vec_data", 32'(write_data), 32'(vecs[v].data));
      end
      @(negedge clk);
      check("vec_idle_busy", 32'(busy), 0);
    end

    // Reset in the middle of a frame, asserted between clock edges.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_fc",   32'(frame_count), 0);
    @(negedge clk);
    rst = 1'b1;
    exp_fc = 0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 1);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'hA5); send_byte(8'hA7);
    exp_fc = 1;
    check("resync_we",   32'(write_enable), 1);
    check("resync_addr", 32'(write_addr), 32'h0002);
    check("resync_data", 32'(write_data), 32'h00A5);
    check("resync_fc",   32'(frame_count), 1);
    repeat (3) @(negedge clk);

    // Randomized frames with junk, gaps, bad checksums and bad addresses.
    clear_obs();
    stream.delete();
    for (int f = 0; f < 60; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        stream.push_back(b);
      end
      a = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'($urandom_range(0, 11));
      d = 16'($urandom);
      if ($urandom_range(0, 4) == 0) d[7:0] = 8'hA5;
      x = a[15:8] ^ a[7:0] ^ d[15:8] ^ d[7:0];
      if ($urandom_range(0, 4) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
      stream.push_back(8'hA5);
      stream.push_back(a[15:8]); stream.push_back(a[7:0]);
      stream.push_back(d[15:8]); stream.push_back(d[7:0]);
      stream.push_back(x);
    end
    model_stream(stream);
    for (int k = 0; k < stream.size(); k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      send_byte(stream[k]);
    end
    repeat (3) @(negedge clk);
    compare_obs("rand");

    // Back-to-back good frames with valid held high, driving the counter to saturation.
    clear_obs();
    stream.delete();
    for (int f = 0; f < 262; f++) begin
      a = 16'(f % 8);
      d = 16'(f * 37);
      stream.push_back(8'hA5);
      stream.push_back(a[15:8]); stream.push_back(a[7:0]);
      stream.push_back(d[15:8]); stream.push_back(d[7:0]);
      stream.push_back(a[15:8] ^ a[7:0] ^ d[15:8] ^ d[7:0]);
    end
    model_stream(stream);
    for (int k = 0; k < stream.size(); k++) send_byte(stream[k]);
    repeat (3) @(negedge clk);
    compare_obs("b2b");
    check("b2b_ready_low_cycles", 32'(rdy_low_n), 262);
    check("b2b_fc_sat", 32'(frame_count), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
